game_sequencer: RTL

- Top-level period controller for SymCounter gameplay.
- Walks each round through prelim, game, answer and post periods, timed by the 1 Hz tick.
- Drives the one-hot period strobes, `level` and the `levelChng` pulse consumed by the clock generator, and exposes a seconds-remaining count for the 7-seg display.
- Tracks the player's answer result to decide whether to advance the level or end the game.

---
 rtl/game_sequencer_pkg.sv | 26 ++
 rtl/game_sequencer_if.sv | 30 +++
 rtl/game_sequencer_timer.sv | 36 +++
 rtl/game_sequencer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/game_sequencer_pkg.sv
// Shared types and default timing constants for the SymCounter game sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRELIM,
    GAME,
    ANSWER,
    POST,
    OVER
  } state_e;

  localparam int unsigned PRELIM_SEC_DEF = 3;
  localparam int unsigned GAME_SEC_DEF   = 20;
  localparam int unsigned ANSWER_SEC_DEF = 10;
  localparam int unsigned POST_SEC_DEF   = 3;
  localparam int unsigned MAX_LEVEL_DEF  = 5;

  localparam int unsigned SEC_W   = 6;
  localparam int unsigned LEVEL_W = 5;

  function automatic logic [SEC_W-1:0] sec_val(input int unsigned s);
    return SEC_W'(s);
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Gameplay control bus: tick/button/answer inputs and period/level/status outputs.
interface game_sequencer_if;

  logic                        Clk1Hz;
  logic                        start;
  logic                        answerDone;
  logic                        answerCorrect;
  logic                        prelimPeriod;
  logic                        gamePeriod;
  logic                        answerPeriod;
  logic                        postPeriod;
  logic                        levelChng;
  logic [game_pkg::LEVEL_W-1:0] level;
  logic [game_pkg::SEC_W-1:0]   secLeft;
  logic                        gameOver;
  logic                        gameWon;

  modport master (
    output Clk1Hz, start, answerDone, answerCorrect,
    input  prelimPeriod, gamePeriod, answerPeriod, postPeriod,
    input  levelChng, level, secLeft, gameOver, gameWon
  );

  modport slave (
    input  Clk1Hz, start, answerDone, answerCorrect,
    output prelimPeriod, gamePeriod, answerPeriod, postPeriod,
    output levelChng, level, secLeft, gameOver, gameWon
  );

endinterface

// File: rtl/game_sequencer_timer.sv
// Loadable seconds down-counter; holds at 1 and flags expiry on the tick that would pass it.
module period_timer
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [SEC_W-1:0] load_val,
  input  logic             tick,
  output logic [SEC_W-1:0] count,
  output logic             expire
);

  logic [SEC_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && (count_q > SEC_W'(1))) begin
      count_d = count_q - SEC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign expire = tick && (count_q == SEC_W'(1));

endmodule

// File: rtl/game_sequencer.sv
// Round/period sequencer: PRELIM -> GAME -> ANSWER -> POST, advancing level on correct answers.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned PRELIM_SEC = PRELIM_SEC_DEF,
  parameter int unsigned GAME_SEC   = GAME_SEC_DEF,
  parameter int unsigned ANSWER_SEC = ANSWER_SEC_DEF,
  parameter int unsigned POST_SEC   = POST_SEC_DEF,
  parameter int unsigned MAX_LEVEL  = MAX_LEVEL_DEF
) (
  input  logic             Clk100M,
  input  logic             reset,
  game_sequencer_if.slave  bus
);

  state_e               state_q, state_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic                 correct_q, correct_d;
  logic                 won_q, won_d;
  logic                 chng_q, chng_d;
  logic                 over_q, over_d;
  logic [3:0]           period_q, period_d;

  logic                 tmr_load;
  logic [SEC_W-1:0]     tmr_load_val;
  logic                 tmr_tick;
  logic [SEC_W-1:0]     tmr_count;
  logic                 tmr_expire;

  // Ticks only reach the timer inside a timed period, so IDLE/OVER never count down.
  assign tmr_tick = bus.Clk1Hz &&
                    (state_q inside {PRELIM, GAME, ANSWER, POST});

  period_timer u_timer (
    .clk      (Clk100M),
    .rst_n    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .tick     (tmr_tick),
    .count    (tmr_count),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    correct_d    = correct_q;
    won_d        = won_q;
    chng_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d      = PRELIM;
          level_d      = '0;
          correct_d    = 1'b0;
          won_d        = 1'b0;
          tmr_load     = 1'b1;
          tmr_load_val = sec_val(PRELIM_SEC);
        end
      end
      PRELIM: begin
        if (tmr_expire) begin
          state_d      = GAME;
          tmr_load     = 1'b1;
          tmr_load_val = sec_val(GAME_SEC);
        end
      end
      GAME: begin
        if (tmr_expire) begin
          state_d      = ANSWER;
          correct_d    = 1'b0;
          tmr_load     = 1'b1;
          tmr_load_val = sec_val(ANSWER_SEC);
        end
      end
      ANSWER: begin
        // A submitted answer beats a coincident final tick.
        if (bus.answerDone) begin
          state_d      = POST;
          correct_d    = bus.answerCorrect;
          tmr_load     = 1'b1;
          tmr_load_val = sec_val(POST_SEC);
        end else if (tmr_expire) begin
          state_d      = POST;
          correct_d    = 1'b0;
          tmr_load     = 1'b1;
          tmr_load_val = sec_val(POST_SEC);
        end
      end
      POST: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          if (correct_q && (level_q < LEVEL_W'(MAX_LEVEL))) begin
            state_d      = PRELIM;
            level_d      = level_q + LEVEL_W'(1);
            chng_d       = 1'b1;
            tmr_load_val = sec_val(PRELIM_SEC);
          end else begin
            state_d      = OVER;
            won_d        = correct_q;
            tmr_load_val = '0;
          end
        end
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    period_d = {state_d == PRELIM, state_d == GAME, state_d == ANSWER, state_d == POST};
    over_d   = (state_d == OVER);
  end

  always_ff @(posedge Clk100M or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      level_q   <= '0;
      correct_q <= 1'b0;
      won_q     <= 1'b0;
      chng_q    <= 1'b0;
      over_q    <= 1'b0;
      period_q  <= '0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      correct_q <= correct_d;
      won_q     <= won_d;
      chng_q    <= chng_d;
      over_q    <= over_d;
      period_q  <= period_d;
    end
  end

  assign bus.prelimPeriod = period_q[3];
  assign bus.gamePeriod   = period_q[2];
  assign bus.answerPeriod = period_q[1];
  assign bus.postPeriod   = period_q[0];
  assign bus.levelChng    = chng_q;
  assign bus.level        = level_q;
  assign bus.secLeft      = tmr_count;
  assign bus.gameOver     = over_q;
  assign bus.gameWon      = won_q;

endmodule
